hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 1, meaning cycles after issue before a load result is forwardable (range 1..7).
REQ-002 SHALL have parameter MUL_LAT, default 3, meaning cycles after issue before a multiply/divide result is forwardable (range 1..7).
REQ-003 SHALL have parameter NUM_REGS, default 32, meaning architectural registers tracked; register 0 is hardwired zero.
REQ-004 SHALL have parameter PERF_W, default 16, meaning stall performance-counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 id_instr  input  32  RV32 instruction currently in ID.
REQ-008 id_valid  input  1  id_instr holds a real instruction.
REQ-009 ex_ready  input  1  pipeline advances this cycle; low freezes scoreboard.
REQ-010 flush  input  1  kills the ID instruction this cycle.
REQ-011 stall  output  1  freeze IF/ID and insert bubble into ID/EX.
REQ-012 issue  output  1  ID instruction moves to EX this cycle.
REQ-013 busy_vec  output  NUM_REGS  bit r set when register r has a non-zero pending count.
REQ-014 stall_cnt  output  PERF_W  saturating count of cycles with stall high.

Function
REQ-015 Each register r≠0 SHALL own a 3-bit pending counter cnt[r]; cnt[0] SHALL be constant 0.
REQ-016 Source use SHALL be decoded from opcode: rs1 used except LUI 0110111, AUIPC 0010111, JAL 1101111; rs2 used only for 0110011, 0100011, 1100011.
REQ-017 Producer latency SHALL be LOAD_LAT for opcode 0000011, MUL_LAT for opcode 0110011 with funct7=0000001, 0 for all other opcodes with rd; S 0100011 and B 1100011 SHALL have no rd.
REQ-018 stall SHALL be combinational: id_valid & ~flush & (rs1 used & cnt[rs1]≠0 | rs2 used & cnt[rs2]≠0).
REQ-019 issue SHALL equal id_valid & ex_ready & ~flush & ~stall.
REQ-020 When ex_ready=1, every non-zero counter SHALL decrement by 1 per cycle, saturating at 0.
REQ-021 On issue of a producer with rd≠0 and latency L>0, cnt[rd] SHALL load max(L, cnt[rd]-1) (WAW-safe); latency 0 leaves cnt[rd] to decrement normally.
REQ-022 When ex_ready=0, all counters SHALL hold; stall still evaluated against held values.
REQ-023 flush SHALL force stall=0 and issue=0 and SHALL NOT clear counters of already-issued producers.
REQ-024 busy_vec SHALL reflect registered counters (no combinational path from id_instr).
REQ-025 stall_cnt SHALL increment each cycle stall=1 and saturate at all-ones.
REQ-026 Default parameters SHALL reproduce classic single-cycle load-use behaviour: exactly one stall cycle for an immediately dependent instruction.

Reset
REQ-027 On rst_n low, all counters, busy_vec and stall_cnt SHALL clear to 0 asynchronously; stall and issue follow from cleared state.
REQ-028 Reset asserted mid-operation SHALL discard all pending counts; first cycle after release SHALL not stall.

Structure
REQ-029 Opcode constants, funct7 MUL value and default latencies SHALL live in shared package hazard_pkg.
REQ-030 Source-use and producer-latency decode SHALL be sub-module hazard_src_decode (pure combinational); counters live in hazard_scoreboard.

Verification
REQ-031 LW x5 issued, next ID ADD x6,x5,x1, ex_ready=1 -> stall=1 one cycle, issue next cycle, stall_cnt=1.
REQ-032 MUL x7 (MUL_LAT=3) then dependent SUB x8,x7,x7 -> stall 3 cycles; independent ADD x9,x1,x2 -> no stall.
REQ-033 LW x0 then ADD x1,x0,x0; LUI x3 after LW x3 -> no stall in either case.
REQ-034 LW x5 issued, ex_ready=0 for 4 cycles with dependent in ID -> stall held 4 cycles, counter frozen at 1, released one cycle after ex_ready=1.
REQ-035 MUL x4 then LW x4 (LOAD_LAT=1) -> cnt[4] keeps max value (2), dependent stalls 2 cycles.
REQ-036 rst_n pulsed low while cnt[5]=1 -> busy_vec=0, stall_cnt=0, dependent issues immediately after release.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared opcode constants, default latencies and counter type
//                for the ID-stage hazard scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int          c_xlen             = 32;
    localparam int          c_cnt_w            = 3;

    // RV32 major opcodes that influence source use or producer latency
    localparam logic [6:0]  c_opc_load         = 7'b0000011;
    localparam logic [6:0]  c_opc_store        = 7'b0100011;
    localparam logic [6:0]  c_opc_branch       = 7'b1100011;
    localparam logic [6:0]  c_opc_op           = 7'b0110011;
    localparam logic [6:0]  c_opc_lui          = 7'b0110111;
    localparam logic [6:0]  c_opc_auipc        = 7'b0010111;
    localparam logic [6:0]  c_opc_jal          = 7'b1101111;

    // funct7 that turns an OP instruction into a multiply/divide
    localparam logic [6:0]  c_funct7_muldiv    = 7'b0000001;

    localparam int          c_default_load_lat = 1;
    localparam int          c_default_mul_lat  = 3;

    typedef logic [c_cnt_w-1:0] cnt_t;

    // Decrement that sticks at zero
    function automatic cnt_t sat_dec(input cnt_t v);
        return (v == '0) ? v : v - cnt_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_if
//  Description : ID-stage handshake between the pipeline control and the
//                hazard scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if;
    import hazard_pkg::*;

    logic [c_xlen-1:0] id_instr;
    logic              id_valid;
    logic              ex_ready;
    logic              flush;
    logic              stall;
    logic              issue;

    // Pipeline control side
    modport master (
        output id_instr,
        output id_valid,
        output ex_ready,
        output flush,
        input  stall,
        input  issue
    );

    // Scoreboard side
    modport slave (
        input  id_instr,
        input  id_valid,
        input  ex_ready,
        input  flush,
        output stall,
        output issue
    );

endinterface
`default_nettype wire

// File: rtl/hazard_src_decode.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_src_decode
//  Description : Pure combinational decode of register sources, destination
//                and result latency of the instruction in ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_src_decode
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = c_default_load_lat,
    parameter int MUL_LAT  = c_default_mul_lat
) (
    input  wire logic [c_xlen-1:0] i_instr,
    output logic                   o_rs1_used,
    output logic                   o_rs2_used,
    output logic                   o_has_rd,
    output logic [4:0]             o_rs1,
    output logic [4:0]             o_rs2,
    output logic [4:0]             o_rd,
    output cnt_t                   o_lat
);

    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    logic       w_unused_funct3;

    assign w_opcode        = i_instr[6:0];
    assign w_funct7        = i_instr[31:25];
    assign w_unused_funct3 = ^i_instr[14:12];

    assign o_rd  = i_instr[11:7];
    assign o_rs1 = i_instr[19:15];
    assign o_rs2 = i_instr[24:20];

    // U-type and JAL carry no rs1 field; only R, S and B carry rs2
    assign o_rs1_used = !(w_opcode inside {c_opc_lui, c_opc_auipc, c_opc_jal});
    assign o_rs2_used =  (w_opcode inside {c_opc_op, c_opc_store, c_opc_branch});
    assign o_has_rd   = !(w_opcode inside {c_opc_store, c_opc_branch});

    // Result latency: loads and mul/div are late producers, everything else forwards at once
    always_comb begin
        o_lat = '0;
        if (w_opcode == c_opc_load) begin
            o_lat = cnt_t'(LOAD_LAT);
        end else if ((w_opcode == c_opc_op) && (w_funct7 == c_funct7_muldiv)) begin
            o_lat = cnt_t'(MUL_LAT);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Per-register pending-latency counters that stall the ID
//                stage on RAW hazards against late-forwarding producers.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = c_default_load_lat,
    parameter int MUL_LAT  = c_default_mul_lat,
    parameter int NUM_REGS = 32,
    parameter int PERF_W   = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_scoreboard_if.slave sb,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [PERF_W-1:0]   stall_cnt
);

    logic              w_rs1_used;
    logic              w_rs2_used;
    logic              w_has_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [4:0]        w_rd;
    cnt_t              w_lat;
    logic [NUM_REGS-1:0] w_busy;
    logic [31:0]       w_busy_ext;
    logic              w_stall;
    logic              w_issue;
    logic [PERF_W-1:0] r_stall_cnt;

    hazard_src_decode #(
        .LOAD_LAT (LOAD_LAT),
        .MUL_LAT  (MUL_LAT)
    ) u_decode (
        .i_instr    (sb.id_instr),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used),
        .o_has_rd   (w_has_rd),
        .o_rs1      (w_rs1),
        .o_rs2      (w_rs2),
        .o_rd       (w_rd),
        .o_lat      (w_lat)
    );

    // Register 0 never has a pending write
    assign w_busy[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        cnt_t r_cnt;
        logic w_load;
        cnt_t w_dec;

        assign w_dec  = sat_dec(r_cnt);
        assign w_load = w_issue && w_has_rd && (w_rd == 5'(r)) && (w_lat != '0);

        // Count down while the pipe advances; a new late producer keeps the larger remaining wait
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (sb.ex_ready) begin
                if (w_load) begin
                    r_cnt <= (w_lat > w_dec) ? w_lat : w_dec;
                end else begin
                    r_cnt <= w_dec;
                end
            end
        end

        assign w_busy[r] = |r_cnt;
    end

    // Widen so any 5-bit register index selects a valid bit
    assign w_busy_ext = 32'(w_busy);

    assign w_stall = sb.id_valid && !sb.flush &&
                     ((w_rs1_used && w_busy_ext[w_rs1]) ||
                      (w_rs2_used && w_busy_ext[w_rs2]));
    assign w_issue = sb.id_valid && sb.ex_ready && !sb.flush && !w_stall;

    assign sb.stall = w_stall;
    assign sb.issue = w_issue;
    assign busy_vec = w_busy;

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {PERF_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
